// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// Runs beside the single-cycle ALU on the same rs1/rs2 operands. The control
// unit issues start and then stalls on busy. done pulses for one cycle when
// result is valid.
//
// Multiply: radix-2 shift-add on operand magnitudes, with the sign fixed up
// at the end. Divide: restoring division on magnitudes, truncating toward
// zero. Divide-by-zero and signed overflow bypass the iteration and complete
// on the start edge.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   start   in   operation request; only sampled while busy=0
//   flush   in   synchronous abort of the operation in flight
//   op      in   funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                       4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a, b    in   rs1 / rs2 operands
//   busy    out  operation in progress; start is ignored
//   done    out  one-cycle pulse; result is valid
//   result  out  result register; held until the next accepted operation
//
// State table
//   state  | meaning
//   S_IDLE | waiting for start; fast-path ops complete here
//   S_CALC | XLEN shift-add or subtract-compare iterations
//   S_FIN  | sign correction and result select, then load result
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]   X_ONE    = XLEN'(1);
  localparam logic [2*XLEN-1:0] P_ONE    = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic             a_neg_q;
  logic             b_neg_q;
  // hi_q: upper product half / partial remainder.
  // lo_q: multiplier then lower product half / dividend then quotient.
  // bv_q: multiplicand / divisor magnitude.
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  bv_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  result_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // Input decode: sign handling, magnitudes and fast-path detection
  // ---------------------------------------------------------------------------
  logic            a_sgn_in, b_sgn_in;
  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            fast_in;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    a_sgn_in = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn_in = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg_in = a_sgn_in && a[XLEN-1];
    b_neg_in = b_sgn_in && b[XLEN-1];
    // The magnitude of the most-negative value still fits as unsigned XLEN.
    a_mag_in = a_neg_in ? (~a + X_ONE) : a;
    b_mag_in = b_neg_in ? (~b + X_ONE) : b;

    // Divide by zero, or signed DIV/REM (op[0]=0) overflowing on MIN / -1.
    fast_in  = op[2] && ((b == '0) ||
                         (!op[0] && (a == MOST_NEG) && (b == '1)));
    if (b == '0) begin
      fast_res = op[1] ? a : '1;
    end else begin
      fast_res = op[1] ? '0 : MOST_NEG;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ok;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier bit is set,
    // then shift the {carry, hi, lo} chain right by one.
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? bv_q : '0)};
    // Restoring divide: bring in the next dividend bit, try subtracting.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, bv_q};
    div_ok    = !div_diff[XLEN];

    if (op_q[2]) begin
      step_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ok};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final sign correction and result select
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, quot_s, rem_s, fin_res;

  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = (a_neg_q ^ b_neg_q) ? (~prod + P_ONE) : prod;
    mul_res = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quot_s  = (a_neg_q ^ b_neg_q) ? (~lo_q + X_ONE) : lo_q;
    // Remainder follows the sign of the dividend.
    rem_s   = a_neg_q ? (~hi_q + X_ONE) : hi_q;
    if (op_q[2]) begin
      fin_res = op_q[1] ? rem_s : quot_s;
    end else begin
      fin_res = mul_res;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush && !fast_in) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = done_q;
    result = result_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      bv_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            if (fast_in) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
            end else begin
              // Multiply is commutative, so both op classes share one load:
              // lo holds a (multiplier / dividend), bv holds b.
              op_q    <= op;
              a_neg_q <= a_neg_in;
              b_neg_q <= b_neg_in;
              hi_q    <= '0;
              lo_q    <= a_mag_in;
              bv_q    <= b_mag_in;
              cnt_q   <= '0;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_FIN: begin
          if (!flush) begin
            result_q <= fin_res;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (XLEN=32): directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN32  = 32'h8000_0000;
  localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;
  localparam int LAT_CALC = XLEN + 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RISC-V M semantics with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    r  = '0;
    case (o)
      3'd0: begin p = sx * sy; r = p[31:0];  end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = ONES32;
        else if (x == MIN32 && y == ONES32) r = MIN32;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: begin
        if (y == 0) r = ONES32;
        else begin p = ux / uy; r = p[31:0]; end
      end
      3'd6: begin
        if (y == 0) r = x;
        else if (x == MIN32 && y == ONES32) r = 32'd0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: begin
        if (y == 0) r = x;
        else begin p = ux % uy; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] o,
                                     input logic [31:0] x,
                                     input logic [31:0] y);
    bit is_div, signed_div;
    is_div     = (o >= 3'd4);
    signed_div = (o == 3'd4) || (o == 3'd6);
    if (is_div && (y == 0 || (signed_div && x == MIN32 && y == ONES32)))
      return 1;
    return LAT_CALC;
  endfunction

  // Issue one operation and wait (bounded) for done. lat counts clock edges
  // from the start edge (inclusive) up to the edge after which done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] res,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = 999;
    res = result;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] as  [4] = '{32'd7, MIN32, ONES32, ONES32};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, MIN32, ONES32, ONES32};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, ONES32};
    logic [31:0] res;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bc);
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      checks++;
      if (lat !== LAT_CALC) begin errors++; $display("FAIL mul_latency[%0d] got=%0d exp=%0d", i, lat, LAT_CALC); end
      checks++;
      if (bc !== XLEN + 1) begin errors++; $display("FAIL mul_busy_cycles[%0d] got=%0d exp=%0d", i, bc, XLEN + 1); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse[%0d] got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, ONES32, 32'd14, 32'd2};
    logic [31:0] res;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bc);
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL div_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      checks++;
      if (lat !== LAT_CALC) begin errors++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, LAT_CALC); end
    end
  endtask

  task automatic test_fast_path;
    logic [2:0]  ops [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, MIN32, MIN32};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, ONES32, ONES32};
    logic [31:0] exp [4] = '{ONES32, 32'd5, MIN32, 32'd0};
    logic [31:0] res;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bc);
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL fast_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL fast_latency[%0d] got=%0d exp=1", i, lat); end
      checks++;
      if (bc !== 0 || busy !== 1'b0) begin errors++; $display("FAIL fast_busy[%0d] got=%0d exp=0", i, bc); end
    end
  endtask

  task automatic test_back_to_back_fast;
    @(negedge clk);
    op = 3'd5; a = 32'd5; b = 32'd0; start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== ONES32) begin
      errors++; $display("FAIL b2b_first got done=%b res=%h exp done=1 res=%h", done, result, ONES32);
    end
    op = 3'd7; a = 32'd9; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'd9) begin
      errors++; $display("FAIL b2b_second got done=%b res=%h exp done=1 res=9", done, result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 5) begin op = 3'd4; a = 32'd100; b = 32'd7; start = 1'b1; end
      if (lat == 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== LAT_CALC) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT_CALC); end
    checks++;
    if (result !== 32'd15) begin errors++; $display("FAIL ignore_result got=%h exp=f", result); end
    // Start in the done cycle must be accepted.
    op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL done_cycle_start_busy got=%b exp=1", busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== LAT_CALC || result !== 32'd14) begin
      errors++; $display("FAIL done_cycle_start got lat=%0d res=%h exp lat=%0d res=e", lat, result, LAT_CALC);
    end
  endtask

  task automatic test_flush_reset;
    logic [31:0] res;
    int lat, bc, dcnt;
    run_op(3'd0, 32'd6, 32'd7, res, lat, bc);
    checks++;
    if (res !== 32'd42) begin errors++; $display("FAIL flush_setup got=%h exp=2a", res); end
    // Flush in flight.
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_state got busy=%b done=%b exp busy=0 done=0", busy, done);
    end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    checks++;
    if (dcnt !== 0 || result !== 32'd42) begin
      errors++; $display("FAIL flush_no_done got dones=%0d res=%h exp dones=0 res=2a", dcnt, result);
    end
    // Flush together with start in IDLE: start (even a fast-path one) is dropped.
    op = 3'd5; a = 32'd1; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd42) begin
      errors++; $display("FAIL flush_start_idle got busy=%b done=%b res=%h exp 0 0 2a", busy, done, result);
    end
    // Asynchronous reset mid-operation.
    op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL async_reset got busy=%b done=%b res=%h exp 0 0 0", busy, done, result);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd0, 32'd2, 32'd2, res, lat, bc);
    checks++;
    if (res !== 32'd4 || lat !== LAT_CALC) begin
      errors++; $display("FAIL post_reset_mul got res=%h lat=%0d exp res=4 lat=%0d", res, lat, LAT_CALC);
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y, res, exp;
    int lat, bc, elat;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       x = MIN32;
        1:       x = 32'($urandom_range(0, 20));
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       y = 32'd0;
        1:       y = ONES32;
        2:       y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      exp  = ref_model(o, x, y);
      elat = ref_latency(o, x, y);
      run_op(o, x, y, res, lat, bc);
      checks++;
      if (res !== exp || lat !== elat) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got res=%h lat=%0d exp res=%h lat=%0d",
                 i, o, x, y, res, lat, exp, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_back_to_back_fast();
    test_busy_ignore();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in operand width.
- Sits beside the single-cycle ALU in the datapath and takes the same rs1/rs2 operands.
- Uses a start/busy/done handshake so the control unit can stall the PC and the register-file write while an operation runs.
- Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU by radix-2 shift-add multiply and restoring divide.

Parameters:
XLEN  32  operand/result width in bits; any value >= 4
CNT_W  $clog2(XLEN)+1  iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only while busy=0
flush  input  1  synchronous abort of the operation in flight
op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  XLEN  rs1 operand
b  input  XLEN  rs2 operand
busy  output  1  operation in progress; new start ignored
done  output  1  one-cycle pulse; result valid this cycle
result  output  XLEN  result register; holds its value until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, result=0, counter=0, internal operand/accumulator registers=0. This applies even mid-operation; no done is issued for the aborted op.
- States:
  - IDLE: waits for start.
  - CALC: XLEN iterations.
  - FIN: sign correction and result selection.
- Transitions:
  - IDLE -> CALC on start=1 at edge T. op, |a| and |b| are latched at T, along with the sign flags per op: MULH/DIV/REM treat both operands as signed; MULHSU treats a signed, b unsigned; the rest are unsigned. busy=1 from T.
  - CALC stays for XLEN edges, counter counting 0..XLEN-1, one shift-add or one subtract-compare per edge. CALC -> FIN after the XLEN-th iteration.
  - FIN -> IDLE on the next edge, which loads result and sets done=1 and busy=0. done is therefore high during the cycle after edge T+XLEN+1, i.e. latency XLEN+2 edges (34 for XLEN=32).
- Fast path (IDLE, start=1, divide op with b=0, or signed DIV/REM with a=most-negative and b=-1): no CALC. result is loaded and done=1 at edge T; busy stays 0.
  - b=0: DIV/DIVU quotient = all-ones; REM/REMU remainder = a.
  - Overflow: DIV quotient = most-negative (1 followed by XLEN-1 zeros); REM remainder = 0.
- Multiply uses a 2*XLEN product of magnitudes. MUL returns bits [XLEN-1:0]; MULH/MULHSU/MULHU return bits [2XLEN-1:XLEN]. The product is negated (two's complement, 2*XLEN wide) when the operand signs differ.
- Divide follows RISC-V truncation toward zero:
  - the quotient is negated when the signs of a and b differ;
  - the remainder takes the sign of a.
- start while busy=1 is ignored and does not disturb the op in flight. start in the same cycle done=1 is accepted, since busy=0 then.
- flush=1 while busy: state=IDLE, busy=0 at the next edge, no done, result unchanged. flush in IDLE has no effect. flush and start together in IDLE: flush wins and start is dropped.
- done is never high for more than one consecutive cycle unless back-to-back fast-path ops occur.
- op values are all legal; no X on result under any input.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD, start at T -> busy 1 from T to T+XLEN+1; done at T+34; result=0xFFFFFFEB.
2. MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. Each completes at latency 34.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
4. Corner cases, each done one edge after start with busy never high:
   - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. Start MUL 3*5. At T+5 pulse start with a DIV -> ignored; result=15 at T+34. Issue a new start in the done cycle -> accepted.
6. Start DIVU. At T+10 assert flush -> busy=0 next edge, no done, result keeps its prior value. Start again; at T+10 drive reset=0 -> busy/done/result=0 immediately. Release reset; MUL 2*2 -> 4.
